// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path: drain state encoding,
// default geometry and the element-index width helper.
package systolic_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } drain_state_e;

    localparam int unsigned DefOpWidth  = 8;
    localparam int unsigned DefAccWidth = 18;
    localparam int unsigned DefDim      = 2;

    function automatic int unsigned idx_width(input int unsigned dim);
        return $clog2(dim * dim);
    endfunction

endpackage

// File: rtl/systolic_result_drain_if.sv
// Valid/ready result stream from the drain to the downstream consumer.
interface systolic_result_drain_if
    import systolic_pkg::*;
#(
    parameter int unsigned OP_WIDTH = DefOpWidth,
    parameter int unsigned DIM      = DefDim
) ();

    localparam int unsigned IdxWidth = idx_width(DIM);

    logic                out_valid;
    logic                out_ready;
    logic [OP_WIDTH-1:0] out_data;
    logic [IdxWidth-1:0] out_index;
    logic                out_last;
    logic                out_sat;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        output out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        input  out_sat,
        output out_ready
    );

endinterface

// File: rtl/systolic_result_drain_acc_narrow.sv
// Combinational accumulator-to-output narrowing. DRAIN_SATURATE_EN selects clamping
// to the signed output range; otherwise the value wraps and sat is 0.
module acc_narrow
    import systolic_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = DefAccWidth,
    parameter int unsigned OP_WIDTH  = DefOpWidth
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OP_WIDTH-1:0]  data,
    output logic                 sat
);

`ifdef DRAIN_SATURATE_EN
    if (ACC_WIDTH > OP_WIDTH) begin : g_clamp
        logic sign;
        logic in_range;
        assign sign = acc[ACC_WIDTH-1];
        // Representable iff every bit from the output sign bit upward equals the sign.
        assign in_range = (acc[ACC_WIDTH-1:OP_WIDTH-1] == {(ACC_WIDTH-OP_WIDTH+1){sign}});
        assign sat  = ~in_range;
        assign data = in_range ? acc[OP_WIDTH-1:0]
                    : (sign ? {1'b1, {(OP_WIDTH-1){1'b0}}} : {1'b0, {(OP_WIDTH-1){1'b1}}});
    end else begin : g_pass
        assign data = acc[OP_WIDTH-1:0];
        assign sat  = 1'b0;
    end
`else
    if (ACC_WIDTH > OP_WIDTH) begin : g_wrap
        logic unused_hi;
        assign unused_hi = ^acc[ACC_WIDTH-1:OP_WIDTH];
    end
    assign data = acc[OP_WIDTH-1:0];
    assign sat  = 1'b0;
`endif

endmodule

// File: rtl/systolic_result_drain.sv
// Captures a DIM x DIM accumulator matrix and streams narrowed elements in row-major
// order. Narrowing mode is set by DRAIN_SATURATE_EN inside acc_narrow.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned OP_WIDTH  = DefOpWidth,
    parameter int unsigned ACC_WIDTH = DefAccWidth,
    parameter int unsigned DIM       = DefDim
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           acc_valid,
    input  logic [DIM*DIM*ACC_WIDTH-1:0]   acc_data,
    output logic                           acc_ready,
    output logic                           busy,
    output logic                           drop_err,
    systolic_result_drain_if.master        out_if
);

    localparam int unsigned NumElem  = DIM * DIM;
    localparam int unsigned IdxWidth = idx_width(DIM);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumElem - 1);

    drain_state_e        state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d, next_idx;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [OP_WIDTH-1:0] data_q, data_d;
    logic                last_q, last_d;
    logic                sat_q, sat_d;
    logic                drop_q, drop_d;
    logic                capture;

    logic [ACC_WIDTH-1:0] buffer_q [NumElem];
    logic [ACC_WIDTH-1:0] narrow_src;
    logic [OP_WIDTH-1:0]  narrow_data;
    logic                 narrow_sat;

    assign next_idx = idx_q + 1'b1;

    // Element 0 is narrowed straight from the input so it is ready the cycle after capture.
    assign narrow_src = (state_q == StIdle) ? acc_data[0 +: ACC_WIDTH] : buffer_q[next_idx];

    acc_narrow #(
        .ACC_WIDTH (ACC_WIDTH),
        .OP_WIDTH  (OP_WIDTH)
    ) u_narrow (
        .acc  (narrow_src),
        .data (narrow_data),
        .sat  (narrow_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        sat_d   = sat_q;
        drop_d  = drop_q | (acc_valid & (state_q == StStream));
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (acc_valid) begin
                    capture = 1'b1;
                    state_d = StStream;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    data_d  = narrow_data;
                    sat_d   = narrow_sat;
                    last_d  = 1'b0;
                end
            end
            StStream: begin
                if (out_if.out_ready) begin
                    if (last_q) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end else begin
                        idx_d  = next_idx;
                        data_d = narrow_data;
                        sat_d  = narrow_sat;
                        last_d = (next_idx == LastIdx);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == StStream);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < int'(NumElem); i++) begin
                buffer_q[i] <= acc_data[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign acc_ready        = (state_q == StIdle);
    assign busy             = busy_q;
    assign drop_err         = drop_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_index = idx_q;
    assign out_if.out_last  = last_q;
    assign out_if.out_sat   = sat_q;

endmodule
